// File: rtl/spi_dump_ctrl.sv
// Command sequencer behind the spi_dump SPI slave: register bank, sample FIFO, response scheduling.
// Optional build macro SPI_DUMP_CTRL_TIMESTAMP_EN: tag carries a free-running cycle stamp.
module spi_dump_ctrl #(
   parameter int unsigned FIFO_AW  = 4,
   parameter logic [15:0] ID_VALUE = 16'hD0C1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [31:0] rx_data,
   input  logic        tx_free,
   output logic        tx_en,
   output logic [31:0] tx_data,
   input  logic        smp_valid,
   input  logic [15:0] smp_data,
   output logic [15:0] cfg_a,
   output logic [15:0] cfg_b,
   output logic        busy
);

   localparam int unsigned DEPTH = 2**FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;
`ifdef SPI_DUMP_CTRL_TIMESTAMP_EN
   localparam int unsigned FW    = 24;
`else
   localparam int unsigned FW    = 16;
`endif

   localparam logic [7:0] OP_STATUS   = 8'h00;
   localparam logic [7:0] OP_WR_REG   = 8'h01;
   localparam logic [7:0] OP_RD_REG   = 8'h02;
   localparam logic [7:0] OP_DUMP     = 8'h03;
   localparam logic [7:0] OP_FIFO_CLR = 8'h04;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_RESP,
      S_DUMP,
      S_DGAP
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [31:0]         r_frame;
   logic [15:0]         r_reg0;
   logic [15:0]         r_reg1;
   logic [15:0]         r_reg2;
   logic [15:0]         r_payload;
   logic                r_err;
   logic [8:0]          r_remain;
   logic                r_ovf;
   logic                r_drop;
   logic                r_tx_en;
   logic [31:0]         r_tx_data;
   logic                r_busy;
   logic [FW-1:0]       r_mem [DEPTH];
   logic [FIFO_AW-1:0]  r_wr_ptr;
   logic [FIFO_AW-1:0]  r_rd_ptr;
   logic [CW-1:0]       r_count;
`ifdef SPI_DUMP_CTRL_TIMESTAMP_EN
   logic [7:0]          r_ts;
`else
   logic [7:0]          r_seq;
`endif

   logic [7:0]          w_op;
   logic [7:0]          w_b0;
   logic [7:0]          w_b1;
   logic [7:0]          w_b2;
   logic [1:0]          w_idx;
   logic [15:0]         w_cnt_ext;
   logic [7:0]          w_cnt8;
   logic [15:0]         w_dec_payload;
   logic                w_dec_err;
   logic                w_fire;
   logic                w_pop_req;
   logic                w_pop;
   logic                w_push_req;
   logic                w_push;
   logic                w_full;
   logic                w_clr;
   logic [CW-1:0]       w_count_next;
   logic [FW-1:0]       w_rd_word;
   logic [FW-1:0]       w_push_data;
   logic [15:0]         w_payload;
   logic                w_err;
   logic                w_empty;
   logic [7:0]          w_tag;
   logic [31:0]         w_word;
   logic [8:0]          w_n;
   logic                w_ovf_set;
   logic                w_drop_set;
   logic                w_sticky_clr;

   assign w_op      = r_frame[7:0];
   assign w_b0      = r_frame[15:8];
   assign w_b1      = r_frame[23:16];
   assign w_b2      = r_frame[31:24];
   assign w_idx     = w_b0[1:0];
   assign w_cnt_ext = 16'(r_count);
   assign w_cnt8    = (w_cnt_ext > 16'd255) ? 8'hFF : w_cnt_ext[7:0];
   assign w_n       = (w_b0 == 8'd0) ? 9'd256 : {1'b0, w_b0};

   // Command decode of the latched frame; only consumed while in DECODE.
   always_comb begin
      w_dec_payload = 16'h0000;
      w_dec_err     = 1'b0;
      case (w_op)
         OP_STATUS: w_dec_payload = {8'h00, w_cnt8};
         OP_WR_REG: begin
            w_dec_payload = {w_b2, w_b1};
            w_dec_err     = (w_idx == 2'd3);
         end
         OP_RD_REG: begin
            case (w_idx)
               2'd0:    w_dec_payload = r_reg0;
               2'd1:    w_dec_payload = r_reg1;
               2'd2:    w_dec_payload = r_reg2;
               default: w_dec_payload = ID_VALUE;
            endcase
         end
         OP_DUMP, OP_FIFO_CLR: w_dec_payload = 16'h0000;
         default:   w_dec_err = 1'b1;
      endcase
   end

   // Next state; w_fire loads the transmit word so tx_en rises in the following cycle.
   always_comb begin
      w_state_next = r_state;
      w_fire       = 1'b0;
      case (r_state)
         S_IDLE:   if (rx_valid) w_state_next = S_DECODE;
         S_DECODE: begin
            w_fire       = tx_free;
            w_state_next = (w_op == OP_DUMP) ? S_DUMP : S_RESP;
         end
         S_RESP: begin
            if (r_tx_en) w_state_next = S_IDLE;
            else         w_fire       = tx_free;
         end
         S_DUMP: begin
            if (r_tx_en) w_state_next = S_DGAP;
            else         w_fire       = tx_free;
         end
         S_DGAP: begin
            if (r_remain != 9'd0) begin
               w_state_next = S_DUMP;
               w_fire       = tx_free;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default:  w_state_next = S_IDLE;
      endcase
   end

   // FIFO control: pop frees space first, clear beats a concurrent push.
   always_comb begin
      w_pop_req    = w_fire && (w_state_next == S_DUMP);
      w_pop        = w_pop_req && (r_count != CW'(0));
      w_push_req   = smp_valid && r_reg0[0];
      w_clr        = (r_state == S_DECODE) && (w_op == OP_FIFO_CLR);
      w_full       = (r_count == CW'(DEPTH));
      w_push       = w_push_req && (!w_full || w_pop) && !w_clr;
      w_ovf_set    = w_push_req && w_full && !w_pop && !w_clr;
      w_count_next = w_clr ? CW'(0) : (r_count + CW'(w_push) - CW'(w_pop));
      w_rd_word    = r_mem[r_rd_ptr];
   end

`ifdef SPI_DUMP_CTRL_TIMESTAMP_EN
   assign w_push_data = {r_ts, smp_data};
   assign w_tag       = w_pop ? w_rd_word[23:16] : r_ts;
`else
   assign w_push_data = smp_data;
   assign w_tag       = r_seq;
`endif

   // Response word assembly at fire time.
   always_comb begin
      if (w_pop_req) begin
         w_payload = w_pop ? w_rd_word[15:0] : 16'h0000;
         w_err     = 1'b0;
         w_empty   = (w_count_next == CW'(0));
      end else if (r_state == S_DECODE) begin
         w_payload = w_dec_payload;
         w_err     = w_dec_err;
         w_empty   = 1'b0;
      end else begin
         w_payload = r_payload;
         w_err     = r_err;
         w_empty   = 1'b0;
      end
      w_word = {w_payload, w_tag, w_op[3:0], w_err, r_ovf, r_drop, w_empty};
   end

   assign w_drop_set   = rx_valid && (r_state != S_IDLE);
   assign w_sticky_clr = (r_state == S_RESP) && r_tx_en && (w_op == OP_STATUS);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Frame latch, register bank, response holding and sticky flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame   <= 32'h0;
         r_reg0    <= 16'h0;
         r_reg1    <= 16'h0;
         r_reg2    <= 16'h0;
         r_payload <= 16'h0;
         r_err     <= 1'b0;
         r_remain  <= 9'd0;
         r_ovf     <= 1'b0;
         r_drop    <= 1'b0;
         r_tx_en   <= 1'b0;
         r_tx_data <= 32'h0;
         r_busy    <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && rx_valid) r_frame <= rx_data;
         if (r_state == S_DECODE) begin
            r_payload <= w_dec_payload;
            r_err     <= w_dec_err;
            if (w_op == OP_WR_REG) begin
               case (w_idx)
                  2'd0:    r_reg0 <= {w_b2, w_b1};
                  2'd1:    r_reg1 <= {w_b2, w_b1};
                  2'd2:    r_reg2 <= {w_b2, w_b1};
                  default: ;
               endcase
            end
            if (w_op == OP_DUMP) r_remain <= w_n - 9'(w_fire);
         end else if (w_pop_req) begin
            r_remain <= r_remain - 9'd1;
         end
         r_ovf   <= w_ovf_set  | (r_ovf  & ~w_sticky_clr);
         r_drop  <= w_drop_set | (r_drop & ~w_sticky_clr);
         r_tx_en <= w_fire;
         if (w_fire) r_tx_data <= w_word;
         r_busy  <= (w_state_next != S_IDLE);
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_data;
   end

`ifdef SPI_DUMP_CTRL_TIMESTAMP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ts <= 8'd0;
      else          r_ts <= r_ts + 8'd1;
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_seq <= 8'd0;
      else if (w_fire) r_seq <= r_seq + 8'd1;
   end
`endif

   assign tx_en   = r_tx_en;
   assign tx_data = r_tx_data;
   assign cfg_a   = r_reg1;
   assign cfg_b   = r_reg2;
   assign busy    = r_busy;

endmodule
